// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing NUM_PORTS common-data-bus slots among NUM_REQ FU writeback requesters.
// Grants are combinational; the broadcast is registered one cycle later.
module cdb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_PORTS = 2,
    parameter int ROB_IDX_W = 5,
    parameter int PRF_IDX_W = 6,
    localparam int PTR_W    = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_id,
    input  logic [NUM_REQ*PRF_IDX_W-1:0]   req_rd_phy,
    input  logic [NUM_REQ*5-1:0]           req_rd_arch,
    input  logic [NUM_REQ*32-1:0]          req_rd_value,
    output logic [NUM_PORTS-1:0]           cdb_valid,
    output logic [NUM_PORTS*ROB_IDX_W-1:0] cdb_rob_id,
    output logic [NUM_PORTS*PRF_IDX_W-1:0] cdb_rd_phy,
    output logic [NUM_PORTS*5-1:0]         cdb_rd_arch,
    output logic [NUM_PORTS*32-1:0]        cdb_rd_value,
    output logic [PTR_W-1:0]               o_dbg_rr_ptr
);

    // Handshake: a requester transfers in a cycle where req_valid & req_ready; an
    // ungranted requester holds valid and payload; the CDB side has no backpressure.

    logic [PTR_W-1:0]     r_rr_ptr;
    logic [NUM_PORTS-1:0] r_cdb_valid;
    logic [ROB_IDX_W-1:0] r_rob    [NUM_PORTS];
    logic [PRF_IDX_W-1:0] r_phy    [NUM_PORTS];
    logic [4:0]           r_arch   [NUM_PORTS];
    logic [31:0]          r_value  [NUM_PORTS];

    logic [NUM_REQ-1:0]   w_ready;
    logic [NUM_PORTS-1:0] w_slot_vld;
    logic [PTR_W-1:0]     w_slot_sel [NUM_PORTS];
    logic [PTR_W-1:0]     w_last;
    logic [PTR_W-1:0]     w_ptr_nxt;
    logic                 w_any;

    // Scan from r_rr_ptr; the k-th valid requester found takes slot k.
    always_comb begin
        int idx;
        int cnt;
        w_ready    = '0;
        w_slot_vld = '0;
        w_last     = '0;
        w_any      = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_slot_sel[p] = '0;
        end
        cnt = 0;
        idx = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = int'(r_rr_ptr) + j;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!rst && !flush && req_valid[idx] && cnt < NUM_PORTS) begin
                w_ready[idx]    = 1'b1;
                w_slot_vld[cnt] = 1'b1;
                w_slot_sel[cnt] = PTR_W'(idx);
                w_last          = PTR_W'(idx);
                w_any           = 1'b1;
                cnt             = cnt + 1;
            end
        end
    end

    assign w_ptr_nxt = (w_last == PTR_W'(NUM_REQ - 1)) ? '0 : w_last + 1'b1;
    assign req_ready = w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_cdb_valid <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_rob[p]   <= '0;
                r_phy[p]   <= '0;
                r_arch[p]  <= '0;
                r_value[p] <= '0;
            end
        end else begin
            if (w_any) begin
                r_rr_ptr <= w_ptr_nxt;
            end
            r_cdb_valid <= w_slot_vld;
            // Idle slots keep their old payload; only the valid bit matters there.
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_slot_vld[p]) begin
                    r_rob[p]   <= req_rob_id[w_slot_sel[p]*ROB_IDX_W +: ROB_IDX_W];
                    r_phy[p]   <= req_rd_phy[w_slot_sel[p]*PRF_IDX_W +: PRF_IDX_W];
                    r_arch[p]  <= req_rd_arch[w_slot_sel[p]*5 +: 5];
                    r_value[p] <= req_rd_value[w_slot_sel[p]*32 +: 32];
                end
            end
        end
    end

    genvar gp;
    generate
        for (gp = 0; gp < NUM_PORTS; gp++) begin : g_port
            assign cdb_rob_id[gp*ROB_IDX_W +: ROB_IDX_W]   = r_rob[gp];
            assign cdb_rd_phy[gp*PRF_IDX_W +: PRF_IDX_W]   = r_phy[gp];
            assign cdb_rd_arch[gp*5 +: 5]                  = r_arch[gp];
            assign cdb_rd_value[gp*32 +: 32]               = r_value[gp];
        end
    endgenerate

    assign cdb_valid    = r_cdb_valid;
    assign o_dbg_rr_ptr = r_rr_ptr;

endmodule
